// File: rtl/rf_write_seq_pkg.sv
// Shared types and default widths for the register-file write sequencer.
package rf_write_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 24;
  localparam int unsigned RF_DEPTH_DEF   = 256;

endpackage

// File: rtl/rf_load_decoder.sv
// Registered one-hot LOAD decoder with an out-of-range flag.
// The flag holds its value until the next enabled decode.
module rf_load_decoder
  import rf_write_seq_pkg::*;
#(
  parameter int unsigned RF_DEPTH   = RF_DEPTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  output logic [RF_DEPTH-1:0]   load_o,
  output logic                  oor_o
);

  logic [RF_DEPTH-1:0] load_d, load_q;
  logic                oor_d, oor_q;
  logic                in_range;

  assign in_range = ({1'b0, target_i} < (ADDR_WIDTH + 1)'(RF_DEPTH));

  // NOTE: every variable driven here gets a default first, so no path leaves a latch.
  always_comb begin
    load_d = '0;
    oor_d  = oor_q;
    for (int i = 0; i < int'(RF_DEPTH); i++) begin
      load_d[i] = en_i && (target_i == ADDR_WIDTH'(i));
    end
    if (en_i) oor_d = !in_range;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= '0;
      oor_q  <= 1'b0;
    end else begin
      load_q <= load_d;
      oor_q  <= oor_d;
    end
  end

  assign load_o = load_q;
  assign oor_o  = oor_q;

endmodule

// File: rtl/rf_write_seq.sv
// Four-phase REQ/ACK write sequencer producing a registered one-hot LOAD
// strobe with DOUT set up one cycle before and held one cycle after it.
module rf_write_seq
  import rf_write_seq_pkg::*;
#(
  parameter int unsigned RF_DEPTH         = RF_DEPTH_DEF,
  parameter int unsigned LC_RF_DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH       = ADDR_WIDTH_DEF
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        REQ,
  input  logic [ADDR_WIDTH-1:0]       ADDR,
  input  logic [LC_RF_DATA_WIDTH-1:0] DATA,
  input  logic                        INC,
  output logic                        ACK,
  output logic                        ERR,
  output logic                        BUSY,
  output logic [LC_RF_DATA_WIDTH-1:0] DOUT,
  output logic [RF_DEPTH-1:0]         LOAD
);

  state_e                        state_d, state_q;
  logic [ADDR_WIDTH-1:0]         target_d, target_q;
  logic [ADDR_WIDTH-1:0]         ptr_d, ptr_q;
  logic [LC_RF_DATA_WIDTH-1:0]   dout_d, dout_q;
  logic                          ack_d, ack_q;
  logic                          err_d, err_q;
  logic                          busy_d, busy_q;
  logic                          dec_en;
  logic                          dec_oor;
  logic [ADDR_WIDTH:0]           tgt_inc;
  logic [ADDR_WIDTH-1:0]         next_ptr;

  // Pointer follows the last successful target, wrapping at RF_DEPTH.
  assign tgt_inc  = {1'b0, target_q} + (ADDR_WIDTH + 1)'(1);
  assign next_ptr = (tgt_inc == (ADDR_WIDTH + 1)'(RF_DEPTH)) ? '0 : tgt_inc[ADDR_WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    ptr_d    = ptr_q;
    dout_d   = dout_q;
    ack_d    = ack_q;
    err_d    = err_q;
    dec_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ && !ack_q) begin
          target_d = INC ? ptr_q : ADDR;
          dout_d   = DATA;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP:  begin
        dec_en  = 1'b1;
        state_d = ST_STROBE;
      end
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        state_d = ST_DONE;
        ack_d   = 1'b1;
        err_d   = dec_oor;
        if (!dec_oor) ptr_d = next_ptr;
      end
      ST_DONE: begin
        if (!REQ) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      ptr_q    <= '0;
      dout_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      ptr_q    <= ptr_d;
      dout_q   <= dout_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  rf_load_decoder #(
    .RF_DEPTH   (RF_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_load_decoder (
    .clk      (CLK),
    .rst      (RESET),
    .en_i     (dec_en),
    .target_i (target_q),
    .load_o   (LOAD),
    .oor_o    (dec_oor)
  );

  assign ACK  = ack_q;
  assign ERR  = err_q;
  assign BUSY = busy_q;
  assign DOUT = dout_q;

endmodule

// File: tb/tb_rf_write_seq.sv
// Directed bench for rf_write_seq with RF_DEPTH=200 so both wrap-around
// and out-of-range addressing can be exercised on one instance.
module tb_rf_write_seq;

  localparam int RF_DEPTH = 200;
  localparam int AW       = 8;
  localparam int DW       = 24;

  logic            CLK;
  logic            RESET;
  logic            REQ;
  logic [AW-1:0]   ADDR;
  logic [DW-1:0]   DATA;
  logic            INC;
  logic            ACK;
  logic            ERR;
  logic            BUSY;
  logic [DW-1:0]   DOUT;
  logic [RF_DEPTH-1:0] LOAD;

  int n_checks;
  int n_errors;

  rf_write_seq #(
    .RF_DEPTH         (RF_DEPTH),
    .LC_RF_DATA_WIDTH (DW),
    .ADDR_WIDTH       (AW)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .REQ   (REQ),
    .ADDR  (ADDR),
    .DATA  (DATA),
    .INC   (INC),
    .ACK   (ACK),
    .ERR   (ERR),
    .BUSY  (BUSY),
    .DOUT  (DOUT),
    .LOAD  (LOAD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction. exp_bit < 0 means no LOAD bit may ever rise.
  task automatic do_write(input string tag, input logic inc, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input int exp_bit, input logic exp_err,
                          input bit drop_early, input int hold);
    logic [255:0] exp_load;
    exp_load = '0;
    if (exp_bit >= 0) exp_load[exp_bit] = 1'b1;
    REQ = 1'b1; INC = inc; ADDR = addr; DATA = data;
    tick();
    check({tag, " dout@k"}, 256'(DOUT), 256'(data));
    check({tag, " load@k"}, 256'(LOAD), '0);
    check({tag, " busy@k"}, 256'(BUSY), 256'(1));
    // Inputs must be ignored after capture.
    ADDR = ~addr; DATA = ~data; INC = ~inc;
    if (drop_early) REQ = 1'b0;
    tick();
    check({tag, " load@k+1"}, 256'(LOAD), exp_load);
    check({tag, " dout@k+1"}, 256'(DOUT), 256'(data));
    tick();
    check({tag, " load@k+2"}, 256'(LOAD), '0);
    check({tag, " dout@k+2"}, 256'(DOUT), 256'(data));
    check({tag, " ack@k+2"}, 256'(ACK), '0);
    tick();
    check({tag, " ack@k+3"}, 256'(ACK), 256'(1));
    check({tag, " err@k+3"}, 256'(ERR), 256'(exp_err));
    check({tag, " load@k+3"}, 256'(LOAD), '0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold load"}, 256'(LOAD), '0);
      check({tag, " hold ack"}, 256'(ACK), 256'(1));
    end
    REQ = 1'b0; INC = 1'b0; ADDR = '0; DATA = '0;
    tick();
    check({tag, " ack drop"}, 256'(ACK), '0);
    check({tag, " err drop"}, 256'(ERR), '0);
    check({tag, " busy end"}, 256'(BUSY), '0);
    check({tag, " dout kept"}, 256'(DOUT), 256'(data));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET = 1'b1; REQ = 1'b0; ADDR = '0; DATA = '0; INC = 1'b0;
    #2;
    check("reset load", 256'(LOAD), '0);
    check("reset ack",  256'(ACK),  '0);
    check("reset err",  256'(ERR),  '0);
    check("reset busy", 256'(BUSY), '0);
    check("reset dout", 256'(DOUT), '0);
    tick();
    RESET = 1'b0;
    tick();

    // Explicit write, then a burst continuing from ptr=6.
    do_write("explicit5", 1'b0, 8'h05, 24'hABCDEF, 5, 1'b0, 1'b0, 0);
    do_write("burst6",    1'b1, 8'h00, 24'h000001, 6, 1'b0, 1'b0, 0);
    do_write("burst7",    1'b1, 8'h00, 24'h000002, 7, 1'b0, 1'b0, 0);
    do_write("burst8",    1'b1, 8'h00, 24'h000003, 8, 1'b0, 1'b0, 0);

    // Wrap-around at RF_DEPTH-1.
    do_write("set198",    1'b0, 8'd198, 24'h123456, 198, 1'b0, 1'b0, 0);
    do_write("wrap199",   1'b1, 8'h00,  24'h654321, 199, 1'b0, 1'b0, 0);
    do_write("wrap0",     1'b1, 8'h00,  24'h0F0F0F, 0,   1'b0, 1'b0, 0);

    // Out-of-range targets leave the pointer unchanged.
    do_write("oor250",    1'b0, 8'd250, 24'hDEAD01, -1, 1'b1, 1'b0, 0);
    do_write("after250",  1'b1, 8'h00,  24'h111111, 1,  1'b0, 1'b0, 0);
    do_write("oor200",    1'b0, 8'd200, 24'hDEAD02, -1, 1'b1, 1'b0, 0);
    do_write("after200",  1'b1, 8'h00,  24'h222222, 2,  1'b0, 1'b0, 0);

    // Handshake abuse: early REQ drop, then REQ held long in DONE.
    do_write("dropearly", 1'b0, 8'd10, 24'hCAFE00, 10, 1'b0, 1'b1, 0);
    do_write("holdreq",   1'b0, 8'd11, 24'hCAFE11, 11, 1'b0, 1'b0, 10);

    // Reset asserted while the strobe is high.
    REQ = 1'b1; INC = 1'b0; ADDR = 8'd20; DATA = 24'h777777;
    tick();
    tick();
    check("pre-reset load", 256'(LOAD), 256'(1) << 20);
    #1 RESET = 1'b1;
    #1;
    check("async load", 256'(LOAD), '0);
    check("async ack",  256'(ACK),  '0);
    check("async dout", 256'(DOUT), '0);
    check("async busy", 256'(BUSY), '0);
    REQ = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    do_write("ptr0",      1'b1, 8'h00, 24'h0A0A0A, 0, 1'b0, 1'b0, 0);
    do_write("reexpl5",   1'b0, 8'h05, 24'hABCDEF, 5, 1'b0, 1'b0, 0);
    do_write("reinc6",    1'b1, 8'h00, 24'h0B0B0B, 6, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
